decouple_sequencer: RTL and testbench
=====================================

Name: decouple_sequencer

Overview:
- Control FSM that drives one AXI-Stream decoupler ahead of partial reconfiguration of one region.
- Accepts a level request from the control register file and asserts passive decouple.
- Waits for drain and escalates to forced decouple on timeout, then reports safe isolation to the PR controller.
- On release, de-asserts decouple and waits until both directions are recoupled.

Parameters:
- DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN and RELEASE before escalation/error (>=1).
- FORCE_TIMEOUT, 256, cycles allowed in FORCE before error (>=1).
- CNT_WIDTH, 16, counter width; must hold max(DRAIN_TIMEOUT, FORCE_TIMEOUT)-1.

Ports:
- aclk  in  1  clock; all logic synchronous to it.
- aresetn  in  1  reset, asynchronous, active-low.
- decouple_req  in  1  level; 1 = region must be isolated.
- force_enable  in  1  permits escalation to forced decouple on drain timeout.
- err_clear  in  1  single-cycle pulse; exits ERROR.
- decouple_done  in  1  from decoupler.
- decouple_status_vector  in  2  from decoupler; bit0 tx decoupled, bit1 rx decoupled.
- decouple  out  1  passive decouple to decoupler.
- decouple_force_tx  out  1  forced tx decouple.
- decouple_force_rx  out  1  forced rx decouple.
- decoupled  out  1  region isolated; PR may proceed.
- busy  out  1  FSM in DRAIN, FORCE or RELEASE.
- timed_out  out  1  sticky; set on any transition to ERROR, cleared by err_clear.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset: state=IDLE, counter=0, forced flag=0. All outputs 0 immediately on aresetn low, including mid-operation.
- All outputs are registered and decoded from next-state, so they change in the same cycle the state register updates.
- "iso" means decouple_done==1 && decouple_status_vector==2'b11.
- IDLE (0): all outputs 0.
  - decouple_req=1 -> DRAIN; counter loads DRAIN_TIMEOUT-1.
- DRAIN (1): decouple=1, busy=1. Priority order:
  - iso -> ISOLATED.
  - decouple_req=0 -> RELEASE (abort).
  - counter==0 and force_enable=1 -> FORCE; counter loads FORCE_TIMEOUT-1; forced flag set.
  - counter==0 and force_enable=0 -> ERROR.
  - Otherwise counter decrements.
- FORCE (2): decouple=1, force_tx=1, force_rx=1, busy=1. Priority order:
  - iso -> ISOLATED.
  - counter==0 -> ERROR.
  - Otherwise decrement.
  - decouple_req=0 is ignored here; it is handled once ISOLATED is reached.
- ISOLATED (3): decouple=1, decoupled=1. force_tx/rx stay 1 if forced flag is set.
  - decouple_req=0 -> RELEASE.
  - iso drops while req=1 -> ERROR.
- RELEASE (4): decouple=0, force outputs 0, forced flag cleared, busy=1; counter loads DRAIN_TIMEOUT-1 on entry.
  - Exits when status==2'b00; rx may stay decoupled until the dropped packet ends.
  - status==2'b00 -> IDLE.
  - counter==0 -> ERROR.
- ERROR (5): fail-safe. decouple=1, force_tx=1, force_rx=1, decoupled=0, timed_out=1.
  - err_clear=1 && decouple_req=0 -> RELEASE; timed_out cleared.
  - err_clear while decouple_req=1 is ignored.
- Simultaneous events:
  - iso and counter==0 in the same cycle: iso wins.
  - iso and req falling in DRAIN: ISOLATED first, RELEASE next cycle.
- The counter never wraps; it holds at 0 outside the counting states.
- Encodings 6 and 7 are illegal and recover to ERROR.

Optional Feature:
- Macro DECOUP_SEQ_STATS_EN.
- With the macro, add ports force_count (out, 16) and error_count (out, 16).
  - Saturating counters increment on each entry to FORCE and to ERROR respectively.
  - Reset to 0 only by aresetn.
- Without the macro, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Bench setup: DRAIN_TIMEOUT=8, FORCE_TIMEOUT=4.
- req=1; iso asserted 3 cycles after decouple rises -> decoupled=1 in the following cycle; force_tx/rx never 1; busy=0 in ISOLATED.
- req=1, force_enable=1, iso withheld -> force_tx/rx=1 exactly 8 cycles after DRAIN entry; iso 2 cycles later -> ISOLATED with force outputs still 1; req=0 -> decouple and force outputs 0 next cycle.
- req=1, force_enable=0, iso withheld -> state=5 and timed_out=1 after 8 cycles; decouple/force stay 1. err_clear with req=1 -> no change. req=0 then err_clear -> RELEASE; status=2'b00 -> IDLE.
- In ISOLATED, req=0; status held 2'b10 for 3 cycles then 2'b00 -> IDLE on the cycle after 2'b00. Repeat holding 2'b10 for 8 cycles -> ERROR.
- aresetn low mid-FORCE -> all outputs 0 asynchronously; after release, state=0. With DECOUP_SEQ_STATS_EN, two forced cycles -> force_count=2, and counts persist across err_clear.

Source files
------------

// File: rtl/decouple_sequencer.sv
// Sequences passive/forced decoupling of one AXI-Stream region around partial reconfiguration.
// Optional DECOUP_SEQ_STATS_EN adds saturating force/error entry counters (force_count, error_count).
module decouple_sequencer #(
  parameter int unsigned DRAIN_TIMEOUT = 1024,
  parameter int unsigned FORCE_TIMEOUT = 256,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       decouple_req,
  input  logic       force_enable,
  input  logic       err_clear,
  input  logic       decouple_done,
  input  logic [1:0] decouple_status_vector,
  output logic       decouple,
  output logic       decouple_force_tx,
  output logic       decouple_force_rx,
  output logic       decoupled,
  output logic       busy,
  output logic       timed_out,
  output logic [2:0] state
`ifdef DECOUP_SEQ_STATS_EN
  ,
  output logic [15:0] force_count,
  output logic [15:0] error_count
`endif
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_DRAIN    = 3'd1;
  localparam logic [2:0] ST_FORCE    = 3'd2;
  localparam logic [2:0] ST_ISOLATED = 3'd3;
  localparam logic [2:0] ST_RELEASE  = 3'd4;
  localparam logic [2:0] ST_ERROR    = 3'd5;

  localparam logic [CNT_WIDTH-1:0] DRAIN_LOAD = CNT_WIDTH'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] FORCE_LOAD = CNT_WIDTH'(FORCE_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

  logic [2:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 forced_q, forced_d;
  logic                 iso, cnt_zero;
  logic                 dec_d, ftx_d, frx_d, dcd_d, busy_d, tout_d;

  assign iso      = decouple_done && (decouple_status_vector == 2'b11);
  assign cnt_zero = (cnt_q == '0);
  assign state    = state_q;

  // Counter defaults to 0 so it holds there in every non-counting state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    forced_d = forced_q;
    case (state_q)
      ST_IDLE: begin
        if (decouple_req) begin
          state_d = ST_DRAIN;
          cnt_d   = DRAIN_LOAD;
        end
      end
      ST_DRAIN: begin
        if (iso) begin
          state_d = ST_ISOLATED;
        end else if (!decouple_req) begin
          state_d = ST_RELEASE;
          cnt_d   = DRAIN_LOAD;
        end else if (cnt_zero) begin
          if (force_enable) begin
            state_d  = ST_FORCE;
            cnt_d    = FORCE_LOAD;
            forced_d = 1'b1;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FORCE: begin
        if (iso) begin
          state_d = ST_ISOLATED;
        end else if (cnt_zero) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ISOLATED: begin
        if (!decouple_req) begin
          state_d = ST_RELEASE;
          cnt_d   = DRAIN_LOAD;
        end else if (!iso) begin
          state_d = ST_ERROR;
        end
      end
      ST_RELEASE: begin
        if (decouple_status_vector == 2'b00) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d = ST_ERROR;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ERROR: begin
        if (err_clear && !decouple_req) begin
          state_d = ST_RELEASE;
          cnt_d   = DRAIN_LOAD;
        end
      end
      default: state_d = ST_ERROR;
    endcase
    if (state_d == ST_RELEASE) forced_d = 1'b0;
  end

  // Outputs decode the next state so they register together with the state.
  always_comb begin
    dec_d  = 1'b0;
    ftx_d  = 1'b0;
    frx_d  = 1'b0;
    dcd_d  = 1'b0;
    busy_d = 1'b0;
    tout_d = 1'b0;
    case (state_d)
      ST_DRAIN: begin
        dec_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_FORCE: begin
        dec_d  = 1'b1;
        ftx_d  = 1'b1;
        frx_d  = 1'b1;
        busy_d = 1'b1;
      end
      ST_ISOLATED: begin
        dec_d = 1'b1;
        dcd_d = 1'b1;
        ftx_d = forced_d;
        frx_d = forced_d;
      end
      ST_RELEASE: busy_d = 1'b1;
      ST_ERROR: begin
        dec_d  = 1'b1;
        ftx_d  = 1'b1;
        frx_d  = 1'b1;
        tout_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q           <= ST_IDLE;
      cnt_q             <= '0;
      forced_q          <= 1'b0;
      decouple          <= 1'b0;
      decouple_force_tx <= 1'b0;
      decouple_force_rx <= 1'b0;
      decoupled         <= 1'b0;
      busy              <= 1'b0;
      timed_out         <= 1'b0;
    end else begin
      state_q           <= state_d;
      cnt_q             <= cnt_d;
      forced_q          <= forced_d;
      decouple          <= dec_d;
      decouple_force_tx <= ftx_d;
      decouple_force_rx <= frx_d;
      decoupled         <= dcd_d;
      busy              <= busy_d;
      timed_out         <= tout_d;
    end
  end

`ifdef DECOUP_SEQ_STATS_EN
  logic [15:0] fcnt_q, ecnt_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      fcnt_q <= '0;
      ecnt_q <= '0;
    end else begin
      if (state_d == ST_FORCE && state_q != ST_FORCE && fcnt_q != '1) fcnt_q <= fcnt_q + 16'd1;
      if (state_d == ST_ERROR && state_q != ST_ERROR && ecnt_q != '1) ecnt_q <= ecnt_q + 16'd1;
    end
  end

  assign force_count = fcnt_q;
  assign error_count = ecnt_q;
`endif

endmodule

// File: tb/tb_decouple_sequencer.sv
// Self-checking bench for decouple_sequencer against a phase/age reference model.
// Build with DECOUP_SEQ_STATS_EN defined to also check the statistics counters.
module tb_decouple_sequencer;
  localparam int DT = 8;
  localparam int FT = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       decouple_req = 1'b0, force_enable = 1'b0, err_clear = 1'b0, decouple_done = 1'b0;
  logic [1:0] decouple_status_vector = 2'b00;
  logic       decouple, decouple_force_tx, decouple_force_rx, decoupled, busy, timed_out;
  logic [2:0] state;
`ifdef DECOUP_SEQ_STATS_EN
  logic [15:0] force_count, error_count;
`endif

  decouple_sequencer #(.DRAIN_TIMEOUT(DT), .FORCE_TIMEOUT(FT), .CNT_WIDTH(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .decouple_req(decouple_req), .force_enable(force_enable),
    .err_clear(err_clear), .decouple_done(decouple_done),
    .decouple_status_vector(decouple_status_vector), .decouple(decouple),
    .decouple_force_tx(decouple_force_tx), .decouple_force_rx(decouple_force_rx),
    .decoupled(decoupled), .busy(busy), .timed_out(timed_out), .state(state)
`ifdef DECOUP_SEQ_STATS_EN
    , .force_count(force_count), .error_count(error_count)
`endif
  );

  always #5 aclk = ~aclk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: named phase plus number of cycles spent in it.
  typedef enum int {P_IDLE = 0, P_DRAIN = 1, P_FORCE = 2, P_ISO = 3, P_REL = 4, P_ERR = 5} phase_t;
  phase_t m_ph;
  int     m_age;
  bit     m_forced;
  int     m_fcnt, m_ecnt;

  function automatic void model_reset();
    m_ph = P_IDLE; m_age = 0; m_forced = 0; m_fcnt = 0; m_ecnt = 0;
  endfunction

  function automatic void model_step();
    bit     isolated = decouple_done && decouple_status_vector == 2'b11;
    phase_t nx = m_ph;
    case (m_ph)
      P_IDLE:  if (decouple_req) nx = P_DRAIN;
      P_DRAIN: if (isolated) nx = P_ISO;
               else if (!decouple_req) nx = P_REL;
               else if (m_age + 1 >= DT) nx = force_enable ? P_FORCE : P_ERR;
      P_FORCE: if (isolated) nx = P_ISO;
               else if (m_age + 1 >= FT) nx = P_ERR;
      P_ISO:   if (!decouple_req) nx = P_REL;
               else if (!isolated) nx = P_ERR;
      P_REL:   if (decouple_status_vector == 2'b00) nx = P_IDLE;
               else if (m_age + 1 >= DT) nx = P_ERR;
      P_ERR:   if (err_clear && !decouple_req) nx = P_REL;
      default: nx = P_ERR;
    endcase
    if (nx == P_FORCE && m_ph != P_FORCE) begin
      m_forced = 1;
      if (m_fcnt < 65535) m_fcnt++;
    end
    if (nx == P_ERR && m_ph != P_ERR && m_ecnt < 65535) m_ecnt++;
    if (nx == P_REL) m_forced = 0;
    m_age = (nx == m_ph) ? m_age + 1 : 0;
    m_ph = nx;
  endfunction

  // {decouple, force_tx, force_rx, decoupled, busy, timed_out, state}
  function automatic logic [8:0] model_out();
    logic [5:0] f;
    case (m_ph)
      P_DRAIN: f = 6'b100010;
      P_FORCE: f = 6'b111010;
      P_ISO:   f = {1'b1, m_forced, m_forced, 1'b1, 2'b00};
      P_REL:   f = 6'b000010;
      P_ERR:   f = 6'b111001;
      default: f = 6'b000000;
    endcase
    return {f, 3'(int'(m_ph))};
  endfunction

  function automatic logic [8:0] dut_out();
    return {decouple, decouple_force_tx, decouple_force_rx, decoupled, busy, timed_out, state};
  endfunction

  task automatic tick();
    @(posedge aclk);
    model_step();
    #1;
  endtask

  task automatic set_iso(input bit on);
    decouple_done = on;
    decouple_status_vector = on ? 2'b11 : 2'b00;
  endtask

  task automatic test_reset();
    aresetn = 0;
    model_reset();
    #3;
    n_total++;
    if (dut_out() !== 9'd0) $display("FAIL reset_outputs: got %b want %b", dut_out(), 9'd0);
    else n_pass++;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
    tick();
    n_total++;
    if (dut_out() !== model_out()) $display("FAIL reset_idle: got %b want %b", dut_out(), model_out());
    else n_pass++;
  endtask

  task automatic test_passive();
    bit saw_force = 0;
    int rise = -1;
    decouple_req = 1;
    for (int i = 0; i < 4 && rise < 0; i++) begin
      tick();
      saw_force |= decouple_force_tx | decouple_force_rx;
      if (decouple === 1'b1) rise = i;
    end
    n_total++;
    if (rise != 0) $display("FAIL passive_rise: got %0d want 0", rise);
    else n_pass++;
    repeat (2) begin
      tick();
      saw_force |= decouple_force_tx | decouple_force_rx;
    end
    set_iso(1);
    tick();
    saw_force |= decouple_force_tx | decouple_force_rx;
    n_total++;
    if (dut_out() !== model_out()) $display("FAIL passive_iso: got %b want %b", dut_out(), model_out());
    else n_pass++;
    n_total++;
    if ({decoupled, busy, saw_force} !== 3'b100)
      $display("FAIL passive_flags: got %b want 100", {decoupled, busy, saw_force});
    else n_pass++;
    decouple_req = 0;
    set_iso(0);
    tick();
    tick();
    n_total++;
    if (state !== 3'd0 || dut_out() !== model_out())
      $display("FAIL passive_idle: got %b want %b", dut_out(), model_out());
    else n_pass++;
  endtask

  task automatic test_force();
    int first = -1;
    force_enable = 1;
    decouple_req = 1;
    tick();
    for (int k = 1; k <= 12 && first < 0; k++) begin
      tick();
      if (decouple_force_tx === 1'b1 && decouple_force_rx === 1'b1) first = k;
    end
    n_total++;
    if (first != DT) $display("FAIL force_latency: got %0d want %0d", first, DT);
    else n_pass++;
    tick();
    set_iso(1);
    tick();
    n_total++;
    if (dut_out() !== model_out() || {decoupled, decouple_force_tx, decouple_force_rx} !== 3'b111)
      $display("FAIL force_iso: got %b want %b", dut_out(), model_out());
    else n_pass++;
    decouple_req = 0;
    tick();
    n_total++;
    if ({decouple, decouple_force_tx, decouple_force_rx} !== 3'b000 || dut_out() !== model_out())
      $display("FAIL force_release: got %b want %b", dut_out(), model_out());
    else n_pass++;
    set_iso(0);
    force_enable = 0;
    tick();
  endtask

  task automatic test_error();
    decouple_req = 1;
    force_enable = 0;
    tick();
    repeat (DT) tick();
    n_total++;
    if (dut_out() !== model_out() || dut_out() !== 9'b111001_101)
      $display("FAIL error_entry: got %b want %b", dut_out(), 9'b111001_101);
    else n_pass++;
    err_clear = 1;
    tick();
    err_clear = 0;
    n_total++;
    if (state !== 3'd5 || timed_out !== 1'b1) $display("FAIL error_clear_ignored: got %0d want 5", state);
    else n_pass++;
    decouple_req = 0;
    tick();
    err_clear = 1;
    tick();
    err_clear = 0;
    n_total++;
    if (state !== 3'd4 || timed_out !== 1'b0 || dut_out() !== model_out())
      $display("FAIL error_to_release: got %b want %b", dut_out(), model_out());
    else n_pass++;
    tick();
    n_total++;
    if (state !== 3'd0) $display("FAIL error_to_idle: got %0d want 0", state);
    else n_pass++;
  endtask

  task automatic test_release_hold();
    int hit = -1;
    decouple_req = 1;
    set_iso(1);
    tick();
    tick();
    decouple_req = 0;
    decouple_done = 0;
    decouple_status_vector = 2'b10;
    repeat (3) tick();
    decouple_status_vector = 2'b00;
    tick();
    n_total++;
    if (state !== 3'd0 || dut_out() !== model_out())
      $display("FAIL release_rx_hold: got %b want %b", dut_out(), model_out());
    else n_pass++;
    decouple_req = 1;
    set_iso(1);
    tick();
    tick();
    decouple_req = 0;
    decouple_done = 0;
    decouple_status_vector = 2'b10;
    tick();
    for (int k = 1; k <= 12 && hit < 0; k++) begin
      tick();
      if (state === 3'd5) hit = k;
    end
    n_total++;
    if (hit != DT) $display("FAIL release_timeout: got %0d want %0d", hit, DT);
    else n_pass++;
    decouple_status_vector = 2'b00;
    err_clear = 1;
    tick();
    err_clear = 0;
    tick();
    n_total++;
    if (state !== 3'd0 || dut_out() !== model_out())
      $display("FAIL release_recover: got %b want %b", dut_out(), model_out());
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    force_enable = 1;
    decouple_req = 1;
    tick();
    repeat (DT - 1) tick();
    set_iso(1);
    tick();
    n_total++;
    if (state !== 3'd3 || decouple_force_tx !== 1'b0 || dut_out() !== model_out())
      $display("FAIL iso_beats_timeout: got %b want %b", dut_out(), model_out());
    else n_pass++;
    decouple_req = 0;
    set_iso(0);
    tick();
    tick();
    decouple_req = 1;
    tick();
    set_iso(1);
    decouple_req = 0;
    tick();
    n_total++;
    if (state !== 3'd3) $display("FAIL iso_and_drop_first: got %0d want 3", state);
    else n_pass++;
    tick();
    n_total++;
    if (state !== 3'd4 || dut_out() !== model_out())
      $display("FAIL iso_and_drop_second: got %b want %b", dut_out(), model_out());
    else n_pass++;
    set_iso(0);
    force_enable = 0;
    tick();
  endtask

  task automatic test_async_reset();
    force_enable = 1;
    decouple_req = 1;
    tick();
    repeat (DT + 1) tick();
    n_total++;
    if (state !== 3'd2) $display("FAIL async_setup_force: got %0d want 2", state);
    else n_pass++;
    @(negedge aclk);
    #2 aresetn = 0;
    #1;
    model_reset();
    n_total++;
    if (dut_out() !== 9'd0) $display("FAIL async_reset_outputs: got %b want %b", dut_out(), 9'd0);
    else n_pass++;
    decouple_req = 0;
    force_enable = 0;
    @(posedge aclk);
    #1 aresetn = 1;
    tick();
    n_total++;
    if (state !== 3'd0 || dut_out() !== model_out())
      $display("FAIL async_after_release: got %b want %b", dut_out(), model_out());
    else n_pass++;
  endtask

`ifdef DECOUP_SEQ_STATS_EN
  task automatic test_stats();
    repeat (2) begin
      force_enable = 1;
      decouple_req = 1;
      tick();
      repeat (DT + FT) tick();
      decouple_req = 0;
      tick();
      err_clear = 1;
      tick();
      err_clear = 0;
      tick();
    end
    n_total++;
    if (force_count !== 16'd2 || error_count !== 16'd2)
      $display("FAIL stats_counts: got %0d/%0d want 2/2", force_count, error_count);
    else n_pass++;
    force_enable = 0;
  endtask
`endif

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) decouple_req = ~decouple_req;
      if ($urandom_range(31) == 0) force_enable = ~force_enable;
      err_clear = ($urandom_range(7) == 0);
      case ($urandom_range(5))
        0: set_iso(1);
        1: begin
          decouple_done = 1'($urandom_range(1));
          decouple_status_vector = 2'($urandom_range(3));
        end
        default: ;
      endcase
      tick();
      n_total++;
      if (dut_out() !== model_out()) begin
        if (bad < 10) $display("FAIL random_cycle_%0d: got %b want %b", i, dut_out(), model_out());
        bad++;
      end else n_pass++;
    end
`ifdef DECOUP_SEQ_STATS_EN
    n_total++;
    if (force_count !== 16'(m_fcnt) || error_count !== 16'(m_ecnt))
      $display("FAIL random_stats: got %0d/%0d want %0d/%0d", force_count, error_count, m_fcnt, m_ecnt);
    else n_pass++;
`endif
    decouple_req = 0;
    err_clear = 0;
    force_enable = 0;
    set_iso(0);
  endtask

  initial begin
    test_reset();
    test_passive();
    test_force();
    test_error();
    test_release_hold();
    test_simultaneous();
    test_async_reset();
`ifdef DECOUP_SEQ_STATS_EN
    test_stats();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
